addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_if.sv | 40 ++++
 rtl/addsub_arbiter.sv | 108 ++++++++++
 tb/tb_addsub_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle for addsub_arbiter: two requester channels sharing
// one add/sub unit and a single registered response channel.
interface addsub_arbiter_if #(
  parameter int W = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_pos_ovf;
  logic         rsp_neg_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_pos_ovf, rsp_neg_ovf
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_pos_ovf, rsp_neg_ovf
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared signed add/sub unit,
// with a single registered response stage (latency 1, one op per cycle).
module addsub_arbiter #(
  parameter int W   = 32,
  parameter int SAT = 0
) (
  input logic              clk,
  input logic              rst,
  addsub_arbiter_if.slave  bus
);

  logic         prio;
  logic         grant;
  logic         can_accept;
  logic         ready0;
  logic         ready1;
  logic         accept;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic [W-1:0] b_eff;
  logic [W-1:0] sum;
  logic         pos_ovf;
  logic         neg_ovf;
  logic [W-1:0] result;

  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic [W-1:0] rsp_result_q;
  logic         rsp_pos_ovf_q;
  logic         rsp_neg_ovf_q;

  assign can_accept = ~rsp_valid_q | bus.rsp_ready;

  always_comb begin
    grant = prio;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readies are held low during reset so nothing is accepted into a stage being cleared.
  assign ready0 = ~rst & can_accept & ~grant & bus.req0_valid;
  assign ready1 = ~rst & can_accept &  grant & bus.req1_valid;
  assign accept = ready0 | ready1;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // Only the granted requester's operands reach the datapath.
  always_comb begin
    op_a   = bus.req0_a;
    op_b   = bus.req0_b;
    op_sub = bus.req0_sub;
    if (grant) begin
      op_a   = bus.req1_a;
      op_b   = bus.req1_b;
      op_sub = bus.req1_sub;
    end
  end

  // Subtraction as a + ~b + 1; the sign of ~b is the effective sign of -b for overflow.
  assign b_eff   = op_sub ? ~op_b : op_b;
  assign sum     = op_a + b_eff + {{(W-1){1'b0}}, op_sub};
  assign pos_ovf = ~op_a[W-1] & ~b_eff[W-1] &  sum[W-1];
  assign neg_ovf =  op_a[W-1] &  b_eff[W-1] & ~sum[W-1];

  always_comb begin
    result = sum;
    if (SAT != 0) begin
      if (pos_ovf) begin
        result = {1'b0, {(W-1){1'b1}}};
      end else if (neg_ovf) begin
        result = {1'b1, {(W-1){1'b0}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_pos_ovf_q <= 1'b0;
      rsp_neg_ovf_q <= 1'b0;
      prio          <= 1'b0;
    end else if (accept) begin
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= grant;
      rsp_result_q  <= result;
      rsp_pos_ovf_q <= pos_ovf;
      rsp_neg_ovf_q <= neg_ovf;
      prio          <= ~grant;
    end else if (bus.rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_pos_ovf = rsp_pos_ovf_q;
  assign bus.rsp_neg_ovf = rsp_neg_ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: wrap (SAT=0) and clamp (SAT=1) instances driven
// identically and compared each cycle against an arithmetic reference model.
module tb_addsub_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0, v1, s0, s1, rr;
  logic [31:0] a0, b0, a1, b1;

  addsub_arbiter_if #(.W(32)) if0 ();
  addsub_arbiter_if #(.W(32)) if1 ();

  assign if0.req0_valid = v0;  assign if1.req0_valid = v0;
  assign if0.req0_a     = a0;  assign if1.req0_a     = a0;
  assign if0.req0_b     = b0;  assign if1.req0_b     = b0;
  assign if0.req0_sub   = s0;  assign if1.req0_sub   = s0;
  assign if0.req1_valid = v1;  assign if1.req1_valid = v1;
  assign if0.req1_a     = a1;  assign if1.req1_a     = a1;
  assign if0.req1_b     = b1;  assign if1.req1_b     = b1;
  assign if0.req1_sub   = s1;  assign if1.req1_sub   = s1;
  assign if0.rsp_ready  = rr;  assign if1.rsp_ready  = rr;

  addsub_arbiter #(.W(32), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(if0.slave));
  addsub_arbiter #(.W(32), .SAT(1)) u_sat  (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [1:0]  o_r0, o_r1, o_val, o_id, o_pos, o_neg;
  logic [31:0] o_res [2];
  assign o_r0  = {if1.req0_ready,  if0.req0_ready};
  assign o_r1  = {if1.req1_ready,  if0.req1_ready};
  assign o_val = {if1.rsp_valid,   if0.rsp_valid};
  assign o_id  = {if1.rsp_id,      if0.rsp_id};
  assign o_pos = {if1.rsp_pos_ovf, if0.rsp_pos_ovf};
  assign o_neg = {if1.rsp_neg_ovf, if0.rsp_neg_ovf};
  assign o_res[0] = if0.rsp_result;
  assign o_res[1] = if1.rsp_result;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact signed arithmetic in 64 bits, then wrap or clamp.
  task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input bit sat, output logic [31:0] res, output logic pos,
                        output logic neg);
    longint x, y, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    r = sub ? x - y : x + y;
    pos = (r > 64'sd2147483647);
    neg = (r < -64'sd2147483648);
    res = r[31:0];
    if (sat && pos) res = 32'h7FFF_FFFF;
    if (sat && neg) res = 32'h8000_0000;
  endtask

  logic        m_val [2] = '{1'b0, 1'b0};
  logic        m_id  [2] = '{1'b0, 1'b0};
  logic        m_pos [2] = '{1'b0, 1'b0};
  logic        m_neg [2] = '{1'b0, 1'b0};
  logic        m_prio[2] = '{1'b0, 1'b0};
  logic [31:0] m_res [2] = '{32'h0, 32'h0};

  // Checks one cycle at the falling edge, then advances the model to the next rising edge.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic who, e0, e1, can;
      logic [31:0] res;
      logic pos, neg;
      can = !m_val[d] || rr;
      who = (v0 && v1) ? m_prio[d] : v1;
      e0  = !rst && can && v0 && (who == 1'b0);
      e1  = !rst && can && v1 && (who == 1'b1);
      chk($sformatf("ready0[%0d]", d), 64'(o_r0[d]), 64'(e0));
      chk($sformatf("ready1[%0d]", d), 64'(o_r1[d]), 64'(e1));
      chk($sformatf("valid[%0d]", d),  64'(o_val[d]), 64'(m_val[d]));
      chk($sformatf("id[%0d]", d),     64'(o_id[d]),  64'(m_id[d]));
      chk($sformatf("result[%0d]", d), 64'(o_res[d]), 64'(m_res[d]));
      chk($sformatf("pos[%0d]", d),    64'(o_pos[d]), 64'(m_pos[d]));
      chk($sformatf("neg[%0d]", d),    64'(o_neg[d]), 64'(m_neg[d]));
      if (rst) begin
        m_val[d] = 0; m_id[d] = 0; m_res[d] = 0; m_pos[d] = 0; m_neg[d] = 0; m_prio[d] = 0;
      end else if (e0 || e1) begin
        if (e1) ref_op(a1, b1, s1, d == 1, res, pos, neg);
        else    ref_op(a0, b0, s0, d == 1, res, pos, neg);
        m_val[d] = 1; m_id[d] = e1; m_res[d] = res; m_pos[d] = pos; m_neg[d] = neg;
        m_prio[d] = !e1;
      end else if (rr) begin
        m_val[d] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    v0 = 0; v1 = 0; s0 = 0; s1 = 0; rr = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    @(posedge clk); #1;
    step();
    rst = 0;

    // Single op with positive overflow
    v0 = 1; a0 = 32'h7FFF_FFFF; b0 = 32'h1; s0 = 0; rr = 1;
    step();
    v0 = 0;
    chk("single_valid",  64'(if0.rsp_valid), 64'd1);
    chk("single_result", 64'(if0.rsp_result), 64'h8000_0000);
    chk("single_pos",    64'(if0.rsp_pos_ovf), 64'd1);
    chk("single_neg",    64'(if0.rsp_neg_ovf), 64'd0);
    chk("single_id",     64'(if0.rsp_id), 64'd0);
    step();

    // Contention from reset: alternating grants starting with requester 0
    rst = 1; step(); rst = 0;
    v0 = 1; a0 = 32'h0000_0010; b0 = 32'h0000_0003; s0 = 0;
    v1 = 1; a1 = 32'h8000_0000; b1 = 32'h0000_0001; s1 = 1; rr = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant0", 64'(if0.req0_ready), 64'(i % 2 == 0));
      chk("rr_grant1", 64'(if0.req1_ready), 64'(i % 2 == 1));
      step();
      if (i % 2 == 1) begin
        chk("rr_result", 64'(if0.rsp_result), 64'h7FFF_FFFF);
        chk("rr_neg",    64'(if0.rsp_neg_ovf), 64'd1);
      end
    end

    // Backpressure: hold the pending response for three cycles
    rr = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready0", 64'(if0.req0_ready), 64'd0);
      chk("bp_ready1", 64'(if0.req1_ready), 64'd0);
      step();
      chk("bp_result", 64'(if0.rsp_result), 64'h7FFF_FFFF);
    end
    rr = 1;
    #1;
    chk("bp_release_ready0", 64'(if0.req0_ready), 64'd1);
    step();
    chk("bp_reload_valid", 64'(if0.rsp_valid), 64'd1);
    chk("bp_reload_id",    64'(if0.rsp_id), 64'd0);
    chk("bp_reload_res",   64'(if0.rsp_result), 64'h0000_0013);
    v1 = 0;

    // Overflow on both sides, wrap vs clamp
    a0 = 32'h8000_0000; b0 = 32'h8000_0000; s0 = 0;
    step();
    chk("sat_neg_res",  64'(if1.rsp_result), 64'h8000_0000);
    chk("sat_neg_flag", 64'(if1.rsp_neg_ovf), 64'd1);
    chk("wrap_neg_res", 64'(if0.rsp_result), 64'h0000_0000);
    a0 = 32'h4000_0000; b0 = 32'h4000_0000;
    step();
    chk("sat_pos_res",  64'(if1.rsp_result), 64'h7FFF_FFFF);
    chk("sat_pos_flag", 64'(if1.rsp_pos_ovf), 64'd1);
    chk("wrap_pos_res", 64'(if0.rsp_result), 64'h8000_0000);

    // Subtracting the most negative value from a non-negative operand
    a0 = 32'h0000_0005; b0 = 32'h8000_0000; s0 = 1;
    step();
    chk("sub_min_pos", 64'(if0.rsp_pos_ovf), 64'd1);
    chk("sub_min_res", 64'(if0.rsp_result), 64'h8000_0005);

    // Non-overflowing subtraction
    a0 = 32'h0000_9644; b0 = 32'h0001_85EF; s0 = 1;
    step();
    chk("nonovf_res", 64'(if0.rsp_result), 64'hFFFF_1055);
    chk("nonovf_flg", 64'({if0.rsp_pos_ovf, if0.rsp_neg_ovf}), 64'd0);

    // Reset with a response held pending
    v0 = 0; rr = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("rst_valid",  64'(if0.rsp_valid), 64'd0);
    chk("rst_result", 64'(if0.rsp_result), 64'd0);
    chk("rst_id",     64'(if0.rsp_id), 64'd0);
    v0 = 1; v1 = 1; rr = 1;
    #1;
    chk("rst_grant0", 64'(if0.req0_ready), 64'd1);
    chk("rst_grant1", 64'(if0.req1_ready), 64'd0);
    step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 7);
      a0 = pick(); b0 = pick(); s0 = $urandom_range(0, 1);
      a1 = pick(); b1 = pick(); s1 = $urandom_range(0, 1);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0; v0 = 0; v1 = 0; rr = 1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
